// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: scrolling 8-glyph display buffer with clear, backspace and timed blinking status messages.
// seg_data is registered from the buffer/state, so every change appears one clk_slow edge later.
module seg_disp_ctrl #(
    parameter int HOLD_TICKS  = 400,
    parameter int BLINK_TICKS = 100
) (
    input  logic        clk_slow,
    input  logic        rst,
    input  logic        ch_valid,
    input  logic [5:0]  ch_code,
    output logic        ch_ready,
    input  logic        clr,
    input  logic        bs,
    input  logic        st_req,
    input  logic [1:0]  st_sel,
    output logic        st_busy,
    output logic [3:0]  char_cnt,
    output logic [63:0] seg_data
);
    localparam int HW = $clog2(HOLD_TICKS) + 1;
    localparam int BW = $clog2(BLINK_TICKS) + 1;

    typedef enum logic {SHOW, STAT} state_t;

    state_t        state_q, state_d;
    logic [63:0]   buf_q, buf_d;
    logic [63:0]   seg_q, seg_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blk_on_q, blk_on_d;

    function automatic logic [7:0] glyph(input logic [5:0] c);
        case (c)
            6'd0:  glyph = 8'hFC;
            6'd1:  glyph = 8'h60;
            6'd2:  glyph = 8'hDA;
            6'd3:  glyph = 8'hF2;
            6'd4:  glyph = 8'h66;
            6'd5:  glyph = 8'hB6;
            6'd6:  glyph = 8'hBE;
            6'd7:  glyph = 8'hE0;
            6'd8:  glyph = 8'hFE;
            6'd9:  glyph = 8'hF6;
            6'd10: glyph = 8'hEE;
            6'd11: glyph = 8'h3E;
            6'd12: glyph = 8'h9C;
            6'd13: glyph = 8'h7A;
            6'd14: glyph = 8'h9E;
            6'd15: glyph = 8'h8E;
            6'd16: glyph = 8'hBC;
            6'd17: glyph = 8'h6E;
            6'd18: glyph = 8'h0C;
            6'd19: glyph = 8'h78;
            6'd20: glyph = 8'hAE;
            6'd21: glyph = 8'h1C;
            6'd22: glyph = 8'hA8;
            6'd23: glyph = 8'h2A;
            6'd24: glyph = 8'hFC;
            6'd25: glyph = 8'hCE;
            6'd26: glyph = 8'hE6;
            6'd27: glyph = 8'h0A;
            6'd28: glyph = 8'hB6;
            6'd29: glyph = 8'h1E;
            6'd30: glyph = 8'h7C;
            6'd31: glyph = 8'h7C;
            6'd32: glyph = 8'h54;
            6'd33: glyph = 8'h6E;
            6'd34: glyph = 8'h76;
            6'd35: glyph = 8'hDA;
            6'd36: glyph = 8'h00;
            default: glyph = 8'h02;
        endcase
    endfunction

    // Messages occupy digits 7..4, left-aligned; three-letter ones end in a blank.
    function automatic logic [31:0] message(input logic [1:0] s);
        message = s == 2'd0 ? 32'h9E0A0A00 :
                  s == 2'd1 ? 32'hFC7C9E0A :
                  s == 2'd2 ? 32'h9C1C0A00 : 32'h7A3A2A9E;
    endfunction

    assign ch_ready = (state_q == SHOW) & ~clr & ~st_req & ~bs;
    assign st_busy  = state_q == STAT;
    assign char_cnt = cnt_q;
    assign seg_data = seg_q;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        blk_cnt_d = blk_cnt_q;
        blk_on_d  = blk_on_q;
        if (clr) begin
            state_d   = SHOW;
            buf_d     = '0;
            cnt_d     = '0;
            hold_d    = '0;
            blk_cnt_d = '0;
            blk_on_d  = 1'b1;
        end else if (state_q == STAT) begin
            state_d   = hold_q == HW'(HOLD_TICKS - 1) ? SHOW : STAT;
            hold_d    = hold_q + 1'b1;
            blk_cnt_d = blk_cnt_q == BW'(BLINK_TICKS - 1) ? '0 : blk_cnt_q + 1'b1;
            blk_on_d  = blk_cnt_q == BW'(BLINK_TICKS - 1) ? ~blk_on_q : blk_on_q;
        end else if (st_req) begin
            state_d   = STAT;
            sel_d     = st_sel;
            hold_d    = '0;
            blk_cnt_d = '0;
            blk_on_d  = 1'b1;
        end else if (bs) begin
            buf_d = cnt_q != 4'd0 ? {8'h00, buf_q[63:8]} : buf_q;
            cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
        end else if (ch_valid) begin
            buf_d = {buf_q[55:0], glyph(ch_code)};
            cnt_d = cnt_q == 4'd8 ? cnt_q : cnt_q + 4'd1;
        end
        seg_d = state_q == SHOW ? buf_q : blk_on_q ? {message(sel_q), 32'h0} : 64'h0;
    end

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            state_q   <= SHOW;
            buf_q     <= '0;
            seg_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            blk_cnt_q <= '0;
            blk_on_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            blk_cnt_q <= blk_cnt_d;
            blk_on_q  <= blk_on_d;
        end
    end
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: directed and randomized checks of seg_disp_ctrl against a glyph-list model.
module tb_seg_disp_ctrl;
    localparam int HOLD  = 400;
    localparam int BLINK = 100;

    logic        clk_slow = 0, rst = 0;
    logic        ch_valid = 0, clr = 0, bs = 0, st_req = 0;
    logic [5:0]  ch_code = 0;
    logic [1:0]  st_sel = 0;
    logic        ch_ready, st_busy;
    logic [3:0]  char_cnt;
    logic [63:0] seg_data;

    int total = 0, bad = 0;

    logic [7:0]  font [37] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6,
                               8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E, 8'hBC, 8'h6E, 8'h0C, 8'h78,
                               8'hAE, 8'h1C, 8'hA8, 8'h2A, 8'hFC, 8'hCE, 8'hE6, 8'h0A, 8'hB6, 8'h1E,
                               8'h7C, 8'h7C, 8'h54, 8'h6E, 8'h76, 8'hDA, 8'h00};
    logic [31:0] msgs [4] = '{32'h9E0A0A00, 32'hFC7C9E0A, 32'h9C1C0A00, 32'h7A3A2A9E};

    // Model: glyphs held newest-last, plus status mode and cycles spent in it.
    logic [7:0]  q[$];
    bit          m_stat = 0;
    int          m_age = 0;
    logic [1:0]  m_sel = 0;
    logic [63:0] exp_seg = 0;

    seg_disp_ctrl #(.HOLD_TICKS(HOLD), .BLINK_TICKS(BLINK)) dut (
        .clk_slow(clk_slow), .rst(rst), .ch_valid(ch_valid), .ch_code(ch_code), .ch_ready(ch_ready),
        .clr(clr), .bs(bs), .st_req(st_req), .st_sel(st_sel), .st_busy(st_busy),
        .char_cnt(char_cnt), .seg_data(seg_data));

    always #5 clk_slow = ~clk_slow;

    function automatic logic [63:0] disp();
        logic [63:0] r;
        r = '0;
        if (m_stat) r = ((m_age / BLINK) % 2 == 0) ? {msgs[m_sel], 32'h0} : 64'h0;
        else for (int i = 0; i < q.size(); i++) r[8*i +: 8] = q[q.size()-1-i];
        return r;
    endfunction

    function automatic bit m_ready();
        return !m_stat && !clr && !st_req && !bs;
    endfunction

    task automatic model_reset();
        q.delete();
        m_stat = 0;
        m_age = 0;
        exp_seg = 0;
    endtask

    task automatic step();
        exp_seg = disp();
        if (clr) begin
            q.delete();
            m_stat = 0;
        end else if (m_stat) begin
            m_age++;
            if (m_age == HOLD) m_stat = 0;
        end else if (st_req) begin
            m_stat = 1;
            m_age = 0;
            m_sel = st_sel;
        end else if (bs) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (ch_valid) begin
            q.push_back(ch_code > 6'd36 ? 8'h02 : font[ch_code]);
            if (q.size() > 8) void'(q.pop_front());
        end
        @(posedge clk_slow);
        #1;
    endtask

    task automatic idle();
        ch_valid = 0; clr = 0; bs = 0; st_req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        #12;
        rst = 0;
        model_reset();
        @(negedge clk_slow);
        total += 4;
        if (seg_data !== 64'h0) begin bad++; $display("FAIL reset_seg got=%h want=0", seg_data); end
        if (char_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", char_cnt); end
        if (st_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", st_busy); end
        if (ch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ch_ready); end
        step();
    endtask

    task automatic test_chars();
        int codes [3] = '{1, 5, 14};
        ch_valid = 1;
        foreach (codes[i]) begin
            ch_code = 6'(codes[i]);
            total++;
            if (ch_ready !== 1'b1) begin bad++; $display("FAIL chars_ready got=%b want=1", ch_ready); end
            step();
        end
        idle();
        step();
        total += 2;
        if (char_cnt !== 4'd3) begin bad++; $display("FAIL chars_cnt got=%0d want=3", char_cnt); end
        if (seg_data !== 64'h60B69E) begin bad++; $display("FAIL chars_seg got=%h want=%h", seg_data, 64'h60B69E); end
    endtask

    task automatic test_saturate();
        clr = 1; step(); clr = 0;
        ch_valid = 1; ch_code = 0;
        repeat (10) step();
        idle(); step();
        total += 2;
        if (char_cnt !== 4'd8) begin bad++; $display("FAIL sat_cnt got=%0d want=8", char_cnt); end
        if (seg_data !== {8{8'hFC}}) begin bad++; $display("FAIL sat_seg got=%h want=%h", seg_data, {8{8'hFC}}); end
        ch_valid = 1; ch_code = 1; step();
        idle(); step();
        total += 2;
        if (char_cnt !== 4'd8) begin bad++; $display("FAIL scroll_cnt got=%0d want=8", char_cnt); end
        if (seg_data !== {{7{8'hFC}}, 8'h60}) begin bad++; $display("FAIL scroll_seg got=%h want=%h", seg_data, {{7{8'hFC}}, 8'h60}); end
    endtask

    task automatic test_backspace();
        logic [63:0] want_seg [3] = '{64'h60, 64'h0, 64'h0};
        int want_cnt [3] = '{1, 0, 0};
        clr = 1; step(); clr = 0;
        ch_valid = 1; ch_code = 1; step();
        ch_code = 5; step();
        idle();
        for (int i = 0; i < 3; i++) begin
            bs = 1; step(); bs = 0; step();
            total += 2;
            if (char_cnt !== 4'(want_cnt[i])) begin bad++; $display("FAIL bs%0d_cnt got=%0d want=%0d", i, char_cnt, want_cnt[i]); end
            if (seg_data !== want_seg[i]) begin bad++; $display("FAIL bs%0d_seg got=%h want=%h", i, seg_data, want_seg[i]); end
        end
    endtask

    task automatic test_status();
        int n;
        ch_valid = 1; ch_code = 2; step();
        ch_code = 3; step();
        ch_code = 7; st_req = 1; st_sel = 0;
        #1;
        total++;
        if (ch_ready !== 1'b0) begin bad++; $display("FAIL stat_req_ready got=%b want=0", ch_ready); end
        step();
        st_req = 0;
        n = 0;
        while (st_busy === 1'b1 && n < 1000) begin
            n++;
            total += 2;
            if (ch_ready !== 1'b0) begin bad++; $display("FAIL stat_ready cyc=%0d got=%b want=0", n, ch_ready); end
            if (seg_data !== exp_seg) begin bad++; $display("FAIL stat_seg cyc=%0d got=%h want=%h", n, seg_data, exp_seg); end
            if (n == 50) begin
                total++;
                if (seg_data !== 64'h9E0A0A00_00000000) begin bad++; $display("FAIL stat_on got=%h want=9e0a0a0000000000", seg_data); end
            end
            if (n == 150) begin
                total++;
                if (seg_data !== 64'h0) begin bad++; $display("FAIL stat_off got=%h want=0", seg_data); end
            end
            step();
        end
        total++;
        if (n != HOLD) begin bad++; $display("FAIL stat_len got=%0d want=%0d", n, HOLD); end
        step();
        total += 2;
        if (seg_data !== 64'hDAF2) begin bad++; $display("FAIL stat_restore got=%h want=daf2", seg_data); end
        if (char_cnt !== 4'd3) begin bad++; $display("FAIL stat_pending_cnt got=%0d want=3", char_cnt); end
        idle(); step();
        total++;
        if (seg_data !== 64'hDAF2E0) begin bad++; $display("FAIL stat_pending_seg got=%h want=daf2e0", seg_data); end
    endtask

    task automatic test_clr_stat();
        st_req = 1; st_sel = 2; step(); st_req = 0;
        repeat (50) step();
        total++;
        if (seg_data !== 64'h9C1C0A00_00000000) begin bad++; $display("FAIL clr_msg got=%h want=9c1c0a0000000000", seg_data); end
        clr = 1; step(); clr = 0;
        total += 2;
        if (st_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b want=0", st_busy); end
        if (char_cnt !== 4'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", char_cnt); end
        step();
        total++;
        if (seg_data !== 64'h0) begin bad++; $display("FAIL clr_seg got=%h want=0", seg_data); end
    endtask

    task automatic test_invalid_rst();
        ch_valid = 1; ch_code = 40; step();
        idle(); step();
        total++;
        if (seg_data[7:0] !== 8'h02) begin bad++; $display("FAIL dash got=%h want=02", seg_data[7:0]); end
        st_req = 1; st_sel = 3; step(); st_req = 0;
        repeat (10) step();
        total++;
        if (seg_data !== 64'h7A3A2A9E_00000000) begin bad++; $display("FAIL done_msg got=%h want=7a3a2a9e00000000", seg_data); end
        #2 rst = 1;
        #1;
        total += 4;
        if (seg_data !== 64'h0) begin bad++; $display("FAIL arst_seg got=%h want=0", seg_data); end
        if (char_cnt !== 4'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", char_cnt); end
        if (st_busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", st_busy); end
        if (ch_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", ch_ready); end
        #1 rst = 0;
        model_reset();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            clr = $urandom_range(0, 63) == 0;
            st_req = $urandom_range(0, 79) == 0;
            bs = $urandom_range(0, 5) == 0;
            ch_valid = $urandom_range(0, 1) == 1;
            ch_code = 6'($urandom_range(0, 63));
            st_sel = 2'($urandom_range(0, 3));
            #1;
            total++;
            if (ch_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready i=%0d got=%b want=%b", i, ch_ready, m_ready()); end
            step();
            total += 3;
            if (seg_data !== exp_seg) begin bad++; $display("FAIL rnd_seg i=%0d got=%h want=%h", i, seg_data, exp_seg); end
            if (char_cnt !== 4'(q.size())) begin bad++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, char_cnt, q.size()); end
            if (st_busy !== m_stat) begin bad++; $display("FAIL rnd_busy i=%0d got=%b want=%b", i, st_busy, m_stat); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_chars();
        test_saturate();
        test_backspace();
        test_status();
        test_clr_stat();
        test_invalid_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
